elevator_car_controller: RTL and testbench



---
 rtl/elevator_pkg.sv | 17 +
 rtl/elevator_car_controller_if.sv | 29 ++
 rtl/elevator_direction_resolver.sv | 27 ++
 rtl/elevator_car_controller.sv | 143 ++++++++++++++
 tb/tb_elevator_car_controller.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller slice.
package elevator_pkg;

   localparam int unsigned NUM_FLOORS = 7;

   typedef logic [2:0] floor_t;
   typedef logic [6:0] queue_t;

   typedef enum logic [1:0] {IDLE, DECIDE, MOVE, DOOR_OPEN} ctrl_state_t;

   // One-hot queue mask for a floor; the invalid floor 7 maps to no bit.
   function automatic queue_t floor_mask(floor_t f);
      floor_mask = '0;
      if (32'(f) < NUM_FLOORS) floor_mask = queue_t'(1) << f;
   endfunction

endpackage

// File: rtl/elevator_car_controller_if.sv
// Call front-end and actuator signals of one elevator car.
interface elevator_car_controller_if;
   import elevator_pkg::*;

   logic   call_valid;
   floor_t call_floor;
   logic   call_ready;
   logic   call_err;
   queue_t queue_status;
   floor_t current_floor;
   logic   up_ndown;
   logic   motor_up;
   logic   motor_down;
   logic   door_open;
   logic   arrived;

   modport master (
      output call_valid, call_floor,
      input  call_ready, call_err, queue_status, current_floor, up_ndown,
             motor_up, motor_down, door_open, arrived
   );

   modport slave (
      input  call_valid, call_floor,
      output call_ready, call_err, queue_status, current_floor, up_ndown,
             motor_up, motor_down, door_open, arrived
   );

endinterface

// File: rtl/elevator_direction_resolver.sv
// Combinational travel-direction choice: keep going while stops remain ahead.
module elevator_direction_resolver
   import elevator_pkg::*;
(
   input  queue_t queue_i,
   input  floor_t floor_i,
   input  logic   up_ndown_i,
   output logic   next_up_ndown_o,
   output logic   queue_empty_o
);

   logic any_above;
   logic any_below;

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (queue_i[i] && (i > 32'(floor_i))) any_above = 1'b1;
         if (queue_i[i] && (i < 32'(floor_i))) any_below = 1'b1;
      end
   end

   assign next_up_ndown_o = any_above && (up_ndown_i || !any_below);
   assign queue_empty_o   = (queue_i == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Elevator car sequencer: queues calls, moves one floor at a time, times the door.
module elevator_car_controller
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS    = 7,
   parameter int unsigned TRAVEL_CYCLES = 8,
   parameter int unsigned DOOR_CYCLES   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   elevator_car_controller_if.slave   bus
);

   localparam int unsigned CntMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] TravelLoad = CntW'(TRAVEL_CYCLES - 1);
   localparam logic [CntW-1:0] DoorLoad   = CntW'(DOOR_CYCLES - 1);
   localparam floor_t TopFloor = floor_t'(NUM_FLOORS - 1);

   ctrl_state_t     state_q, state_d;
   queue_t          queue_q, queue_d;
   floor_t          floor_q, floor_d;
   logic            dir_q, dir_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            arrived_q, arrived_d;
   logic            call_err_q, call_err_d;
   logic            door_q;

   logic   res_up;
   logic   res_empty;
   logic   call_here;
   floor_t next_floor;

   elevator_direction_resolver u_resolver (
      .queue_i         (queue_q),
      .floor_i         (floor_q),
      .up_ndown_i      (dir_q),
      .next_up_ndown_o (res_up),
      .queue_empty_o   (res_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         queue_q    <= '0;
         floor_q    <= '0;
         dir_q      <= 1'b1;
         cnt_q      <= '0;
         arrived_q  <= 1'b0;
         call_err_q <= 1'b0;
         door_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         queue_q    <= queue_d;
         floor_q    <= floor_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         arrived_q  <= arrived_d;
         call_err_q <= call_err_d;
         door_q     <= (state_d == DOOR_OPEN);
      end
   end

   always_comb begin
      state_d    = state_q;
      queue_d    = queue_q;
      floor_d    = floor_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      arrived_d  = 1'b0;
      call_err_d = bus.call_valid && (bus.call_floor == floor_t'(7));
      call_here  = bus.call_valid && (bus.call_floor == floor_q);
      next_floor = dir_q ? floor_q + floor_t'(1) : floor_q - floor_t'(1);

      // A stopped car answers a call for its own floor with the door, not a queued stop.
      if (bus.call_valid && !(call_here && state_q != MOVE)) begin
         queue_d = queue_q | floor_mask(bus.call_floor);
      end

      unique case (state_q)
         IDLE: begin
            if (call_here) begin
               state_d = DOOR_OPEN;
               cnt_d   = DoorLoad;
            end else if (queue_q != '0) begin
               state_d = DECIDE;
            end
         end
         DECIDE: begin
            dir_d = res_up;
            if (call_here) begin
               state_d = DOOR_OPEN;
               cnt_d   = DoorLoad;
            end else if (res_empty) begin
               state_d = IDLE;
            end else begin
               state_d = MOVE;
               cnt_d   = TravelLoad;
            end
         end
         MOVE: begin
            if ((dir_q && floor_q == TopFloor) || (!dir_q && floor_q == '0)) begin
               state_d = DECIDE;
            end else if (cnt_q == '0) begin
               floor_d = next_floor;
               if ((queue_d & floor_mask(next_floor)) != '0) begin
                  queue_d   = queue_d & ~floor_mask(next_floor);
                  arrived_d = 1'b1;
                  cnt_d     = DoorLoad;
                  state_d   = DOOR_OPEN;
               end else begin
                  cnt_d = TravelLoad;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DOOR_OPEN: begin
            if (call_here) begin
               cnt_d = DoorLoad;
            end else if (cnt_q == '0) begin
               state_d = DECIDE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.call_ready    = !rst;
      bus.call_err      = call_err_q;
      bus.queue_status  = queue_q;
      bus.current_floor = floor_q;
      bus.up_ndown      = dir_q;
      bus.motor_up      = (state_q == MOVE) && dir_q;
      bus.motor_down    = (state_q == MOVE) && !dir_q;
      bus.door_open     = door_q;
      bus.arrived       = arrived_q;
   end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller with hand-computed expectations.
module tb_elevator_car_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   elevator_car_controller_if bus ();

   elevator_car_controller #(
      .NUM_FLOORS    (7),
      .TRAVEL_CYCLES (8),
      .DOOR_CYCLES   (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_call(input logic v, input logic [2:0] f);
      bus.call_valid = v;
      bus.call_floor = f;
   endtask

   int n_mot, n_arr, n_door, n_both, first_mot;
   int arr_floor[3];

   initial begin
      drive_call(1'b0, 3'd0);

      // Reset values while rst is held
      @(negedge clk);
      check_eq("rst_ready", 32'(bus.call_ready), 32'd0);
      check_eq("rst_queue", 32'(bus.queue_status), 32'd0);
      check_eq("rst_floor", 32'(bus.current_floor), 32'd0);
      check_eq("rst_dir", 32'(bus.up_ndown), 32'd1);
      check_eq("rst_motor", 32'({bus.motor_up, bus.motor_down}), 32'd0);
      check_eq("rst_misc", 32'({bus.door_open, bus.arrived, bus.call_err}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", 32'(bus.call_ready), 32'd1);

      // Call floor 3 from floor 0; k counts edges after the accepting edge E0
      drive_call(1'b1, 3'd3);
      n_mot = 0; n_arr = 0; n_door = 0; n_both = 0; first_mot = -1;
      for (int k = 0; k <= 50; k++) begin
         @(negedge clk);
         drive_call(1'b0, 3'd0);
         if (k == 0) check_eq("q_after_call3", 32'(bus.queue_status), 32'h08);
         if (bus.motor_up) begin
            n_mot++;
            if (first_mot < 0) first_mot = k;
         end
         if (bus.motor_up && bus.motor_down) n_both++;
         if (bus.arrived) n_arr++;
         if (bus.door_open) n_door++;
         if (k == 9)  check_eq("f_k9", 32'(bus.current_floor), 32'd0);
         if (k == 10) check_eq("f_k10", 32'(bus.current_floor), 32'd1);
         if (k == 18) check_eq("f_k18", 32'(bus.current_floor), 32'd2);
         if (k == 26) begin
            check_eq("f_k26", 32'(bus.current_floor), 32'd3);
            check_eq("arr_k26", 32'({bus.arrived, bus.door_open, bus.motor_up}), 32'b110);
         end
      end
      check_eq("first_motor", 32'(first_mot), 32'd2);
      check_eq("motor_cycles", 32'(n_mot), 32'd24);
      check_eq("arrived_pulses", 32'(n_arr), 32'd1);
      check_eq("door_cycles", 32'(n_door), 32'd16);
      check_eq("motor_both", 32'(n_both), 32'd0);
      check_eq("q_after_trip", 32'(bus.queue_status), 32'd0);

      // Own-floor call in IDLE, reopened after 10 open cycles
      drive_call(1'b1, 3'd3);
      n_door = 0;
      for (int s = 1; s <= 30; s++) begin
         @(negedge clk);
         drive_call(1'b0, 3'd0);
         if (bus.door_open) n_door++;
         if (s == 1) begin
            check_eq("door_next", 32'(bus.door_open), 32'd1);
            check_eq("door_q", 32'(bus.queue_status), 32'd0);
         end
         if (s == 10) drive_call(1'b1, 3'd3);
         if (s == 26) check_eq("door_s26", 32'(bus.door_open), 32'd1);
         if (s == 27) check_eq("door_s27", 32'(bus.door_open), 32'd0);
      end
      check_eq("door_reopen_cycles", 32'(n_door), 32'd26);

      // Invalid floor
      drive_call(1'b1, 3'd7);
      @(negedge clk);
      drive_call(1'b0, 3'd0);
      check_eq("err_pulse", 32'(bus.call_err), 32'd1);
      check_eq("err_queue", 32'(bus.queue_status), 32'd0);
      @(negedge clk);
      check_eq("err_gone", 32'(bus.call_err), 32'd0);
      check_eq("err_state", 32'({bus.door_open, bus.motor_up, bus.motor_down}), 32'd0);

      // Direction priority: heading up to 4 with {1,5} queued -> 4, 5, then 1
      drive_call(1'b1, 3'd4);
      n_arr = 0;
      for (int k = 0; k <= 110; k++) begin
         @(negedge clk);
         if (k == 0) drive_call(1'b1, 3'd5);
         else if (k == 1) drive_call(1'b1, 3'd1);
         else drive_call(1'b0, 3'd0);
         if (bus.arrived) begin
            if (n_arr < 3) arr_floor[n_arr] = 32'(bus.current_floor);
            n_arr++;
         end
         if (k == 2)  check_eq("prio_queue", 32'(bus.queue_status), 32'h32);
         if (k == 30) check_eq("prio_up", 32'({bus.up_ndown, bus.motor_up}), 32'b11);
         if (k == 55) check_eq("prio_down", 32'({bus.up_ndown, bus.motor_down}), 32'b01);
      end
      check_eq("prio_count", 32'(n_arr), 32'd3);
      check_eq("prio_first", 32'(arr_floor[0]), 32'd4);
      check_eq("prio_second", 32'(arr_floor[1]), 32'd5);
      check_eq("prio_third", 32'(arr_floor[2]), 32'd1);
      check_eq("prio_end_floor", 32'(bus.current_floor), 32'd1);
      check_eq("prio_end_queue", 32'(bus.queue_status), 32'd0);

      // Asynchronous reset during MOVE toward floor 5
      drive_call(1'b1, 3'd5);
      for (int k = 0; k <= 11; k++) begin
         @(negedge clk);
         drive_call(1'b0, 3'd0);
      end
      check_eq("pre_rst_floor", 32'(bus.current_floor), 32'd2);
      check_eq("pre_rst_motor", 32'(bus.motor_up), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_floor", 32'(bus.current_floor), 32'd0);
      check_eq("mid_rst_queue", 32'(bus.queue_status), 32'd0);
      check_eq("mid_rst_outs",
               32'({bus.motor_up, bus.motor_down, bus.up_ndown, bus.call_ready}), 32'b0010);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("post_rst_idle",
               32'({bus.call_ready, bus.motor_up, bus.motor_down, bus.door_open}), 32'b1000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
